// File: rtl/processador_pkg.sv
// Shared constants for the program loader: state encoding, default
// instruction-memory capacity and the length-header size.
package processador_pkg;

    localparam int MAX_WORDS_DEFAULT = 64;
    localparam int HDR_BYTES         = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_CHECK  = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;
    localparam logic [2:0] ST_ERROR  = 3'd7;

endpackage

// File: rtl/byte_assembler.sv
// Collects four bytes, least-significant first, into a 32-bit word.
// o_word is the completed word in the same cycle the 4th byte is offered,
// so the caller can register it on the accepting edge.
module byte_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_complete
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    assign o_word          = {i_byte, r_shift};
    assign o_word_complete = i_valid && (r_cnt == 2'd3);

    // Shift accepted bytes in from the top; count bytes within the word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_valid) begin
            r_shift <= {i_byte, r_shift[23:8]};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a length-prefixed byte stream and writes it
// word by word into instruction memory while holding the core in reset.
// Optional trailing XOR checksum byte: define PROGRAM_LOADER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | waiting for start, core held in reset
// LEN_LO | receiving word count, low byte
// LEN_HI | receiving word count, high byte; range check
// DATA   | receiving payload bytes
// WRITE  | one-cycle instruction-memory write of the assembled word
// CHECK  | receiving checksum byte (checksum build only)
// DONE   | load complete, core released
// ERROR  | load aborted, core held in reset
module program_loader
    import processador_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_reset,
    output logic        done,
    output logic        error
);

    localparam int LenBits = 8 * HDR_BYTES;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_LAST = ST_CHECK;
    logic [7:0] r_checksum;
`else
    localparam logic [2:0] ST_LAST = ST_DONE;
`endif

    logic [2:0]         r_state;
    logic [LenBits-1:0] r_len;
    logic [LenBits-1:0] r_word_cnt;
    logic [31:0]        r_imem_addr;
    logic [31:0]        r_imem_wdata;

    logic               w_accept;
    logic               w_clear;
    logic               w_word_complete;
    logic [31:0]        w_word;
    logic [LenBits-1:0] w_len_full;

    assign rx_ready   = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                        (r_state == ST_DATA)   || (r_state == ST_CHECK);
    assign w_accept   = rx_valid && rx_ready;
    assign w_clear    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                  (r_state == ST_ERROR));
    assign w_len_full = {rx_data, r_len[7:0]};

    assign imem_we    = (r_state == ST_WRITE);
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign done       = (r_state == ST_DONE);
    assign error      = (r_state == ST_ERROR);
    assign core_reset = (r_state != ST_DONE);

    byte_assembler u_asm (
        .clock           (clock),
        .reset           (reset),
        .i_clear         (w_clear),
        .i_valid         (w_accept && (r_state == ST_DATA)),
        .i_byte          (rx_data),
        .o_word          (w_word),
        .o_word_complete (w_word_complete)
    );

    // Load sequencing: header, payload words, optional checksum.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_word_cnt   <= '0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_checksum   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        r_state    <= ST_LEN_LO;
                        r_len      <= '0;
                        r_word_cnt <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_checksum <= '0;
`endif
                    end
                end
                ST_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= rx_data;
                        r_state    <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (w_accept) begin
                        r_len <= w_len_full;
                        if (w_len_full > LenBits'(MAX_WORDS))
                            r_state <= ST_ERROR;
                        else if (w_len_full == '0)
                            r_state <= ST_LAST;
                        else
                            r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_checksum <= r_checksum ^ rx_data;
`endif
                        if (w_word_complete) begin
                            r_imem_addr  <= 32'({r_word_cnt, 2'b00});
                            r_imem_wdata <= w_word;
                            r_state      <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                    if (r_word_cnt == r_len - 1'b1)
                        r_state <= ST_LAST;
                    else
                        r_state <= ST_DATA;
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (w_accept)
                        r_state <= (rx_data == r_checksum) ? ST_DONE : ST_ERROR;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader. Checksum scenarios are compiled in
// when PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        error;

    int n_pass  = 0;
    int n_total = 0;
    int wr_cnt  = 0;
    logic [31:0] wr_addr [8];
    logic [31:0] wr_data [8];

    logic [7:0] prog [10] = '{8'h02, 8'h00, 8'h03, 8'h15, 8'h00, 8'h00,
                              8'h83, 8'h15, 8'h40, 8'h00};

    program_loader #(.MAX_WORDS(64)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] b2w(input logic x);
        return {31'b0, x};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Record every write strobe; the strobe spans one whole cycle.
    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            if (wr_cnt < 8) begin
                wr_addr[wr_cnt] = imem_addr;
                wr_data[wr_cnt] = imem_wdata;
            end
            wr_cnt++;
            check("ready_low_in_write", b2w(rx_ready), 32'd0);
        end
    end

    task automatic check_reset_vals();
        check("rst_rx_ready",   b2w(rx_ready),   32'd0);
        check("rst_imem_we",    b2w(imem_we),    32'd0);
        check("rst_imem_addr",  imem_addr,       32'd0);
        check("rst_imem_wdata", imem_wdata,      32'd0);
        check("rst_core_reset", b2w(core_reset), 32'd1);
        check("rst_done",       b2w(done),       32'd0);
        check("rst_error",      b2w(error),      32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        t = 0;
        @(negedge clock);
        if (gap) @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && t < 40) begin
            @(negedge clock);
            t++;
        end
        if (t >= 40) check("rx_ready_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_prog(input bit gap);
        for (int i = 0; i < 10; i++) send_byte(prog[i], gap);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'hC0, gap);
`endif
    endtask

    task automatic wait_end(input int budget);
        int t;
        t = 0;
        while (done !== 1'b1 && error !== 1'b1 && t < budget) begin
            @(negedge clock);
            t++;
        end
        if (t >= budget) check("end_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_writes();
        check("wr_count", wr_cnt,     32'd2);
        check("wr0_addr", wr_addr[0], 32'h0000_0000);
        check("wr0_data", wr_data[0], 32'h0000_1503);
        check("wr1_addr", wr_addr[1], 32'h0000_0004);
        check("wr1_data", wr_data[1], 32'h0040_1583);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #12;
        check_reset_vals();
        @(negedge clock);
        reset = 1'b0;

        // Nominal two-word load.
        wr_cnt = 0;
        pulse_start();
        check("start_rx_ready", b2w(rx_ready), 32'd1);
        check("start_core_rst", b2w(core_reset), 32'd1);
        send_prog(1'b0);
        wait_end(10);
        check_writes();
        check("ok_done",       b2w(done),       32'd1);
        check("ok_core_reset", b2w(core_reset), 32'd0);
        check("ok_error",      b2w(error),      32'd0);
        repeat (3) @(negedge clock);
        check("ok_done_held",  b2w(done),       32'd1);
        check("ok_we_idle",    b2w(imem_we),    32'd0);
        check("ok_wdata_held", imem_wdata,      32'h0040_1583);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Bad checksum byte.
        wr_cnt = 0;
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(prog[i], 1'b0);
        send_byte(8'h00, 1'b0);
        wait_end(10);
        check("cs_wr_count",   wr_cnt,          32'd2);
        check("cs_error",      b2w(error),      32'd1);
        check("cs_core_reset", b2w(core_reset), 32'd1);
        check("cs_done",       b2w(done),       32'd0);
`endif

        // Oversized header: N = 65.
        wr_cnt = 0;
        pulse_start();
        check("big_done_clr", b2w(done), 32'd0);
        send_byte(8'h41, 1'b0);
        send_byte(8'h00, 1'b0);
        check("big_error",      b2w(error),      32'd1);
        check("big_core_reset", b2w(core_reset), 32'd1);
        check("big_done",       b2w(done),       32'd0);
        check("big_rx_ready",   b2w(rx_ready),   32'd0);
        repeat (3) @(negedge clock);
        check("big_no_write",   wr_cnt,          32'd0);

        // Stalled stream: valid low between bytes.
        wr_cnt = 0;
        pulse_start();
        check("stall_err_clr", b2w(error), 32'd0);
        send_prog(1'b1);
        wait_end(40);
        check_writes();
        check("stall_done", b2w(done), 32'd1);

        // Reset after 5th data byte, then full reload.
        wr_cnt = 0;
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(prog[i], 1'b0);
        check("mid_wr_count", wr_cnt,     32'd1);
        check("mid_wdata",    imem_wdata, 32'h0000_1503);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_reset_vals();
        #3 reset = 1'b0;
        wr_cnt = 0;
        pulse_start();
        send_prog(1'b0);
        wait_end(10);
        check_writes();
        check("reload_done", b2w(done), 32'd1);

        // Empty program, with start re-pulsed while in LEN_LO.
        wr_cnt = 0;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        check("n0_lenlo_ready", b2w(rx_ready), 32'd1);
        @(negedge clock);
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        @(posedge clock);
        #1;
        start    = 1'b0;
        rx_valid = 1'b0;
        check("n0_not_yet_done", b2w(done), 32'd0);
        @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        @(posedge clock);
        #1 rx_valid = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        check("n0_in_check_done",  b2w(done),     32'd0);
        check("n0_in_check_ready", b2w(rx_ready), 32'd1);
        send_byte(8'h00, 1'b0);
`endif
        check("n0_done",       b2w(done),       32'd1);
        check("n0_core_reset", b2w(core_reset), 32'd0);
        check("n0_no_write",   wr_cnt,          32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter: MAX_WORDS, default 64, instruction-memory capacity in 32-bit words.
REQ-002 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  one-cycle request to begin a program load.
REQ-005 Port: rx_valid  input  1  byte-stream valid.
REQ-006 Port: rx_data  input  8  byte-stream data.
REQ-007 Port: rx_ready  output  1  loader can accept a byte this cycle.
REQ-008 Port: imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 Port: imem_addr  output  32  byte address of the word being written, always a multiple of 4.
REQ-010 Port: imem_wdata  output  32  word to write.
REQ-011 Port: core_reset  output  1  holds the processor in reset while high.
REQ-012 Port: done  output  1  load completed successfully.
REQ-013 Port: error  output  1  load aborted.

Function
REQ-014 States SHALL be IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR.
REQ-015 A byte SHALL be accepted only on a rising edge where rx_valid and rx_ready are both high.
REQ-016 rx_ready SHALL be high exactly in LEN_LO, LEN_HI, DATA and CHECK.
REQ-017 IDLE, DONE or ERROR with start high SHALL go to LEN_LO and clear done/error, with core_reset high; start SHALL be ignored in every other state.
REQ-018 Stream format SHALL be: word count N (16-bit, little-endian, LEN_LO then LEN_HI), then N words of 4 bytes each, least-significant byte first.
REQ-019 N > MAX_WORDS SHALL go from LEN_HI to ERROR; N = 0 SHALL go to CHECK (or DONE when the checksum is compiled out).
REQ-020 After the 4th byte of word k is accepted, the state SHALL be WRITE for exactly one cycle.
REQ-021 In WRITE, the outputs SHALL be imem_we=1, imem_addr=4*k and imem_wdata=the assembled word; WRITE then goes to DATA, or to CHECK/DONE after word N-1.
REQ-022 imem_we SHALL be 0 in every other state; imem_addr and imem_wdata SHALL hold their last values.
REQ-023 DONE SHALL hold done=1, core_reset=0 and error=0 until start or reset.
REQ-024 ERROR SHALL hold error=1, core_reset=1 and done=0 until start or reset.
REQ-025 rx_valid low mid-word SHALL stall the load without loss; no timeout exists.

Reset
REQ-026 Reset asserted at any time, including mid-load, SHALL immediately set: state=IDLE, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, done=0, error=0, and clear the byte counter, word counter and checksum.
REQ-027 Words already written before a reset are not erased; a new load SHALL be required.

Configuration
REQ-028 With macro PROGRAM_LOADER_CHECKSUM_EN defined, CHECK SHALL accept one byte and compare it with the XOR of all payload bytes.
REQ-029 On a checksum match, CHECK SHALL go to DONE; on a mismatch it SHALL go to ERROR.
REQ-030 Without PROGRAM_LOADER_CHECKSUM_EN, the CHECK state and checksum register SHALL be absent, and the last WRITE (or N=0) SHALL go directly to DONE.

Structure
REQ-031 The state encoding, the MAX_WORDS default and the header byte count SHALL live in the shared package processador_pkg.
REQ-032 One sub-module, byte_assembler, SHALL be used: it shifts 4 bytes into a 32-bit word and flags word_complete.
REQ-033 The loader SHALL instantiate no memory; it only drives the instruction-memory write port.

Verification
REQ-034 Scenario, checksum enabled: reset, start, stream 02 00 03 15 00 00 83 15 40 00 C0 -> writes 0x00001503 @0x00 and 0x00401583 @0x04, then done=1, core_reset=0.
REQ-035 Scenario: the same stream with last byte 00 -> two writes occur, then error=1, core_reset=1, done=0.
REQ-036 Scenario: header 41 00 (N=65, MAX_WORDS=64) -> ERROR after LEN_HI, no imem_we pulse.
REQ-037 Scenario: rx_valid toggled every other cycle during the data bytes -> identical writes, one imem_we pulse per word, rx_ready=0 during each WRITE cycle.
REQ-038 Scenario: reset asserted after the 5th data byte, then a full reload -> all outputs at reset values asynchronously, and the reload writes from 0x00.
REQ-039 Scenario, checksum compiled out: header 00 00 -> DONE two cycles after start with no writes; start pulsed in LEN_LO is ignored.
